// File: rtl/imem_responder.sv
// Instruction-memory responder: LATENCY-cycle read pipeline feeding a 4-entry in-order response FIFO.
// imemreq_rdy drops at 4 outstanding responses so nothing is lost; misalign checking via IMEM_RESPONDER_MISALIGN_CHECK_EN.
module imem_responder #(
    parameter int NWORDS  = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    output logic        imemreq_rdy,
    input  logic [31:0] imemreq_addr,
    output logic        imemresp_val,
    input  logic        imemresp_rdy,
    output logic [31:0] imemresp_data,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
`ifdef IMEM_RESPONDER_MISALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int AW = $clog2(NWORDS);

    logic [31:0]   mem [NWORDS];
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [31:0]   rd_word;
    logic          req_acc;
    logic          fin_vld;
    logic [31:0]   fin_dat;
    logic [2:0]    pipe_cnt;

    assign rd_idx  = imemreq_addr[AW+1:2];
    assign wr_idx  = load_addr[AW+1:2];
    assign req_acc = imemreq_val & imemreq_rdy;

    always_comb begin
        rd_word = mem[rd_idx];
`ifdef IMEM_RESPONDER_MISALIGN_CHECK_EN
        if (imemreq_addr[1:0] != 2'b00) rd_word = 32'h0;
`endif
    end

    // Storage is deliberately not reset; the read above sees the pre-write word.
    always_ff @(posedge clk) begin
        if (load_en) mem[wr_idx] <= load_data;
    end

    generate
        if (LATENCY == 1) begin : g_nopipe
            assign fin_vld  = req_acc;
            assign fin_dat  = rd_word;
            assign pipe_cnt = 3'd0;
        end else begin : g_pipe
            localparam int NS = LATENCY - 1;
            logic [NS-1:0] stg_vld_q, stg_vld_d;
            logic [31:0]   stg_dat_q [NS];
            logic [31:0]   stg_dat_d [NS];

            always_comb begin
                stg_vld_d[0] = req_acc;
                stg_dat_d[0] = rd_word;
                for (int i = 1; i < NS; i++) begin
                    stg_vld_d[i] = stg_vld_q[i-1];
                    stg_dat_d[i] = stg_dat_q[i-1];
                end
                pipe_cnt = 3'd0;
                for (int i = 0; i < NS; i++) pipe_cnt = pipe_cnt + 3'(stg_vld_q[i]);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) stg_vld_q <= '0;
                else     stg_vld_q <= stg_vld_d;
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < NS; i++) stg_dat_q[i] <= stg_dat_d[i];
            end

            assign fin_vld = stg_vld_q[NS-1];
            assign fin_dat = stg_dat_q[NS-1];
        end
    endgenerate

    logic [31:0] fifo_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        pop;

    assign pop = imemresp_val & imemresp_rdy;

    // Admission control guarantees a push never finds the FIFO full without a matching pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q + 2'(fin_vld);
        rd_ptr_d = rd_ptr_q + 2'(pop);
        cnt_d    = cnt_q + 3'(fin_vld) - 3'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fin_vld) fifo_q[wr_ptr_q] <= fin_dat;
    end

    assign imemresp_val  = (cnt_q != 3'd0);
    assign imemresp_data = fifo_q[rd_ptr_q];
    assign imemreq_rdy   = ({1'b0, pipe_cnt} + {1'b0, cnt_q}) < 4'd4;

`ifdef IMEM_RESPONDER_MISALIGN_CHECK_EN
    logic misalign_err_q, misalign_err_d;

    always_comb begin
        misalign_err_d = misalign_err_q | (req_acc & (imemreq_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_err_q <= 1'b0;
        else     misalign_err_q <= misalign_err_d;
    end

    assign misalign_err = misalign_err_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{imemreq_addr[31:AW+2], load_addr[31:AW+2], load_addr[1:0]};
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imemreq_addr[31:AW+2], imemreq_addr[1:0],
                                load_addr[31:AW+2], load_addr[1:0]};
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench: two responders (LATENCY 1 and 3) share stimulus; a word-array model predicts every cycle.
module tb_imem_responder;
    localparam int NW = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_val, resp_rdy, load_en;
    logic [31:0] req_addr, load_addr, load_data;
    logic        rdy0, rdy1, val0, val1;
    logic [31:0] dat0, dat1;
`ifdef IMEM_RESPONDER_MISALIGN_CHECK_EN
    logic        err0, err1;
`endif

    always #5 clk = ~clk;

    imem_responder #(.NWORDS(NW), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .imemreq_val(req_val), .imemreq_rdy(rdy0), .imemreq_addr(req_addr),
        .imemresp_val(val0), .imemresp_rdy(resp_rdy), .imemresp_data(dat0),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
`ifdef IMEM_RESPONDER_MISALIGN_CHECK_EN
        , .misalign_err(err0)
`endif
    );

    imem_responder #(.NWORDS(NW), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .imemreq_val(req_val), .imemreq_rdy(rdy1), .imemreq_addr(req_addr),
        .imemresp_val(val1), .imemresp_rdy(resp_rdy), .imemresp_data(dat1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
`ifdef IMEM_RESPONDER_MISALIGN_CHECK_EN
        , .misalign_err(err1)
`endif
    );

    // Reference model: word array plus a per-instance list of outstanding responses with accept cycle.
    logic [31:0] mem_m [NW];
    logic [31:0] exp_dat [2][8];
    int          exp_cyc [2][8];
    int          hd [2];
    int          tl [2];
    bit          err_m [2];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int lat, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (LATENCY=%0d) cycle %0d: got %h, want %h", name, lat, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [1:0]  rdy_d, val_d, err_d;
        logic [31:0] dat_d [2];
        logic [31:0] word;
        int          outst;
        bit          e_rdy, e_val;
        rdy_d    = {rdy1, rdy0};
        val_d    = {val1, val0};
        dat_d[0] = dat0;
        dat_d[1] = dat1;
`ifdef IMEM_RESPONDER_MISALIGN_CHECK_EN
        err_d = {err1, err0};
`else
        err_d = 2'b00;
`endif
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                check("rdy_in_reset", lat_of(i), 32'(rdy_d[i]), 32'd1);
                check("val_in_reset", lat_of(i), 32'(val_d[i]), 32'd0);
                hd[i]    = 0;
                tl[i]    = 0;
                err_m[i] = 1'b0;
`ifdef IMEM_RESPONDER_MISALIGN_CHECK_EN
                check("misalign_err_in_reset", lat_of(i), 32'(err_d[i]), 32'd0);
`endif
            end else begin
                outst = tl[i] - hd[i];
                e_rdy = (outst < 4);
                e_val = (outst > 0) && (cyc - exp_cyc[i][hd[i] % 8] >= lat_of(i));
                check("imemreq_rdy", lat_of(i), 32'(rdy_d[i]), 32'(e_rdy));
                check("imemresp_val", lat_of(i), 32'(val_d[i]), 32'(e_val));
                if (e_val) check("imemresp_data", lat_of(i), dat_d[i], exp_dat[i][hd[i] % 8]);
`ifdef IMEM_RESPONDER_MISALIGN_CHECK_EN
                check("misalign_err", lat_of(i), 32'(err_d[i]), 32'(err_m[i]));
`endif
                if (e_val && resp_rdy) hd[i]++;
                if (req_val && e_rdy) begin
                    word = mem_m[(req_addr >> 2) % NW];
`ifdef IMEM_RESPONDER_MISALIGN_CHECK_EN
                    if (req_addr % 4 != 0) begin
                        word     = 32'h0;
                        err_m[i] = 1'b1;
                    end
`endif
                    exp_dat[i][tl[i] % 8] = word;
                    exp_cyc[i][tl[i] % 8] = cyc;
                    tl[i]++;
                end
            end
        end
        if (load_en) mem_m[(load_addr >> 2) % NW] = load_data;
        cyc++;
    end

    task automatic drive(input logic v, input logic [31:0] a, input logic le, input logic [31:0] la,
                         input logic [31:0] ld, input logic rr);
        @(posedge clk);
        #1;
        req_val   = v;
        req_addr  = a;
        load_en   = le;
        load_addr = la;
        load_data = ld;
        resp_rdy  = rr;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int k = 0; k < n; k++) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, rr);
    endtask

    task automatic random_phase(input int n);
        for (int k = 0; k < n; k++)
            drive(1'($urandom % 2), $urandom, 1'($urandom % 4 == 0), $urandom, $urandom,
                  1'($urandom % 10 < 7));
    endtask

    initial begin
        rst = 1'b1; req_val = 1'b0; req_addr = '0; resp_rdy = 1'b1;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int w = 0; w < NW; w++) drive(1'b0, 32'h0, 1'b1, 32'(w * 4), $urandom, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 32'h0, 32'h00A00093, 1'b1);

        drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(4, 1'b1);

        drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b1);
        drive(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(4, 1'b1);

        for (int k = 0; k < 8; k++) drive(1'b1, 32'(k * 4), 1'b0, 32'h0, 32'h0, 1'b0);
        idle(2, 1'b0);
        idle(8, 1'b1);

        drive(1'b0, 32'h0, 1'b1, 32'h10, 32'h11111111, 1'b1);
        drive(1'b1, 32'h10, 1'b1, 32'h10, 32'h22222222, 1'b1);
        drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(4, 1'b1);

        drive(1'b0, 32'h0, 1'b1, 32'h0, 32'hDEADBEEF, 1'b1);
        drive(1'b1, 32'h400, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(4, 1'b1);
        drive(1'b1, 32'h2, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(4, 1'b1);

        random_phase(400);

        drive(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 32'h24, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1; req_val = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(8, 1'b1);

        random_phase(300);
        idle(10, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter NWORDS, default 256, number of 32-bit words in storage (power of two, 4..4096).
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request acceptance to earliest response (1..4).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port imemreq_val  input  1  fetch request valid.
REQ-006 SHALL have port imemreq_rdy  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port imemreq_addr  input  32  byte address of fetch.
REQ-008 SHALL have port imemresp_val  output  1  response valid.
REQ-009 SHALL have port imemresp_rdy  input  1  requester accepts response this cycle.
REQ-010 SHALL have port imemresp_data  output  32  instruction word.
REQ-011 SHALL have port load_en  input  1  preload write strobe.
REQ-012 SHALL have port load_addr  input  32  preload byte address.
REQ-013 SHALL have port load_data  input  32  preload word.

Function
REQ-014 SHALL accept a request on a cycle with imemreq_val=1 and imemreq_rdy=1; no other cycle is an accept.
REQ-015 SHALL index storage with addr[log2(NWORDS)+1:2]; higher bits ignored (address wraps modulo 4*NWORDS).
REQ-016 SHALL read the word at acceptance cycle; a same-cycle load_en to the same word returns the old word (read-before-write).
REQ-017 SHALL carry each accepted read through a LATENCY-stage valid/data pipeline, then into a 4-entry in-order response FIFO.
REQ-018 SHALL, for acceptance in cycle k with FIFO empty, assert imemresp_val in cycle k+LATENCY with the read word.
REQ-019 SHALL drive imemresp_val/imemresp_data from FIFO head; pop on imemresp_val=1 and imemresp_rdy=1.
REQ-020 SHALL hold imemresp_data stable while imemresp_val=1 and imemresp_rdy=0.
REQ-021 SHALL drive imemreq_rdy = (in-flight pipeline entries + FIFO occupancy) < 4, combinationally from state only, never from imemreq_val.
REQ-022 SHALL support simultaneous pop and pipeline push into a full FIFO without loss; rdy does not count the popping entry (conservative).
REQ-023 SHALL sustain one accept per cycle when imemresp_rdy is held 1.
REQ-024 SHALL write load_data at the indexed word on load_en edge; loads never generate responses.
REQ-025 SHALL return responses strictly in acceptance order.

Reset
REQ-026 SHALL on rst clear all pipeline valids and empty the FIFO: imemresp_val=0, imemreq_rdy=1 one cycle after deassertion or immediately during reset combinational evaluation.
REQ-027 SHALL discard in-flight requests on reset mid-operation; no stale response after reset release.
REQ-028 SHALL NOT reset storage contents; imemresp_data is don't-care while imemresp_val=0.

Configuration
REQ-029 SHALL with IMEM_RESPONDER_MISALIGN_CHECK_EN defined, return 32'h0 for requests with addr[1:0]!=0 and set sticky output misalign_err (1 bit, cleared only by rst, reset 0).
REQ-030 SHALL without IMEM_RESPONDER_MISALIGN_CHECK_EN, ignore addr[1:0] and omit misalign_err port.

Verification
REQ-031 Preload word 0x00A00093 at 0x0, LATENCY=1, request 0x0 in cycle 0 with resp_rdy=1 -> imemresp_val=1, data 0x00A00093 in cycle 1.
REQ-032 Back-to-back requests 0x0,0x4,0x8 with resp_rdy=1 -> three responses in consecutive cycles, in order, rdy stays 1.
REQ-033 resp_rdy=0, issue requests until rdy=0 -> exactly 4 accepted; raise resp_rdy -> 4 responses in order, rdy returns 1.
REQ-034 Same-cycle request and load to 0x10 (old 0x11111111, new 0x22222222) -> response 0x11111111; next request -> 0x22222222.
REQ-035 Assert rst with 2 requests in flight, LATENCY=3 -> imemresp_val=0 after reset, no response ever emitted for them.
REQ-036 NWORDS=256, request 0x400 after preloading 0x0 with 0xDEADBEEF -> response 0xDEADBEEF (wrap); with IMEM_RESPONDER_MISALIGN_CHECK_EN, request 0x2 -> data 0, misalign_err=1 until rst.
